tx_bit_serializer: RTL and testbench

TX_BIT_SERIALIZER -- requirements
Module: tx_bit_serializer

---
 rtl/usb_tx_pkg.sv | 29 ++
 rtl/tx_bit_timer.sv | 54 +++++
 rtl/tx_bit_serializer.sv | 240 ++++++++++++++++++++++++
 tb/tb_tx_bit_serializer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// -----------------------------------------------------------------------------
// usb_tx_pkg
// Shared definitions for the USB full-speed transmit bit serializer:
//   tx_state_e   - serializer FSM states
//   SYNC_BYTE    - sync pattern sent before every packet (LSB first)
//   STUFF_LIMIT  - consecutive ones that force a stuffed zero
//   EOP_BITS     - bit periods of SE0 at end of packet
//   is_serial()  - true in the states that put bits on the line
// -----------------------------------------------------------------------------
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF,
    EOP,
    EOP_J
  } tx_state_e;

  localparam logic [7:0]  SYNC_BYTE   = 8'h80;
  localparam int unsigned STUFF_LIMIT = 6;
  localparam int unsigned EOP_BITS    = 2;

  function automatic logic is_serial(input tx_state_e s);
    return (s == SYNC) || (s == DATA) || (s == STUFF);
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// -----------------------------------------------------------------------------
// tx_bit_timer
// Bit-period counter for the serializer. While run is high it counts
// 0..CLKS_PER_BIT-1 and wraps; bit_end marks the last cycle of each bit
// period. shift_enable is the same strobe, gated by strobe_en so the line
// strobe is only produced while bits are actually being serialized.
// Ports:
//   clk, n_rst     - clock, asynchronous active-low reset
//   run            - count enable; counter held at 0 while low
//   strobe_en      - allows bit_end onto shift_enable
//   bit_end        - last cycle of the current bit period
//   shift_enable   - bit_end qualified by strobe_en
// -----------------------------------------------------------------------------
module tx_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic run,
  input  logic strobe_en,
  output logic bit_end,
  output logic shift_enable
);

  localparam int unsigned     CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_end      = run && (cnt_q == LAST_CNT);
  assign shift_enable = bit_end && strobe_en;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (!run || bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tx_bit_serializer.sv
// -----------------------------------------------------------------------------
// tx_bit_serializer
// Serializes packet bytes for a USB full-speed transmitter: SYNC, LSB-first
// payload with bit stuffing, then SE0 EOP and one J bit. One holding byte
// decouples the byte source from the shift register.
// Ports:
//   clk, n_rst     - clock, asynchronous active-low reset
//   tx_data/valid/last, tx_ready - byte stream in (valid/ready handshake)
//   d_orig         - un-encoded serial bit to the NRZI encoder
//   shift_enable   - strobe in the last cycle of every line bit (incl. stuff)
//   eop            - high during the SE0 part of end-of-packet
//   busy           - high outside IDLE
//   underrun       - one-cycle pulse when the source starves mid-packet
//   byte_cnt       - bytes sent in this packet (only with TX_BYTE_CNT_EN)
// Build option: define TX_BYTE_CNT_EN to add the byte_cnt output.
// -----------------------------------------------------------------------------
module tx_bit_serializer
  import usb_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       d_orig,
  output logic       shift_enable,
  output logic       eop,
  output logic       busy,
  output logic       underrun
`ifdef TX_BYTE_CNT_EN
  ,
  output logic [6:0] byte_cnt
`endif
);

  tx_state_e  state_q, state_d;
  logic [2:0] bit_idx_q, bit_idx_d;     // bit within byte, or EOP bit count
  logic [2:0] ones_q, ones_d;           // run length of transmitted ones
  logic       byte_done_q, byte_done_d; // stuff bit owed after a byte's 8th bit
  logic [7:0] shift_q, shift_d;
  logic       cur_last_q, cur_last_d;   // byte in shift_q ends the packet
  logic [7:0] buf_q, buf_d;
  logic       buf_last_q, buf_last_d;
  logic       buf_full_q, buf_full_d;
  logic       last_acc_q, last_acc_d;   // tx_last byte already taken
  logic       underrun_q, underrun_d;

  logic       bit_end;
  logic       in_byte;
  logic [7:0] tx_byte;
  logic       cur_bit;
  logic [2:0] ones_inc;
  logic       stuff_needed;
  logic       last_bit;
  logic       at_boundary;
  logic       drain;
  logic       starve;
  logic       accept;

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk         (clk),
    .n_rst       (n_rst),
    .run         (busy),
    .strobe_en   (is_serial(state_q)),
    .bit_end     (bit_end),
    .shift_enable(shift_enable)
  );

  assign in_byte      = (state_q == SYNC) || (state_q == DATA);
  assign tx_byte      = (state_q == SYNC) ? SYNC_BYTE : shift_q;
  assign cur_bit      = tx_byte[bit_idx_q];
  assign ones_inc     = ones_q + 3'd1;
  assign stuff_needed = in_byte && cur_bit && (ones_inc == 3'(STUFF_LIMIT));
  assign last_bit     = (bit_idx_q == 3'd7);

  // A byte boundary is the last cycle of a byte's 8th bit, or of the stuff
  // bit that follows it.
  assign at_boundary = bit_end &&
                       ((in_byte && last_bit && !stuff_needed) ||
                        ((state_q == STUFF) && byte_done_q));
  assign drain  = at_boundary && !cur_last_q && buf_full_q;
  assign starve = at_boundary && !cur_last_q && !buf_full_q;

  // Ready while the holding byte is empty, or in the cycle it drains so
  // back-to-back bytes see no gap. Held low in a starving boundary cycle so
  // a late byte cannot land in the buffer as the packet is being closed.
  assign tx_ready = (state_q == IDLE) ||
                    (is_serial(state_q) && !last_acc_q &&
                     (buf_full_q ? drain : !starve));
  assign accept   = tx_valid && tx_ready;

  assign d_orig   = in_byte ? cur_bit : (state_q != STUFF);
  assign eop      = (state_q == EOP);
  assign busy     = (state_q != IDLE);
  assign underrun = underrun_q;

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    ones_d      = ones_q;
    byte_done_d = byte_done_q;
    shift_d     = shift_q;
    cur_last_d  = cur_last_q;
    buf_d       = buf_q;
    buf_last_d  = buf_last_q;
    buf_full_d  = buf_full_q;
    last_acc_d  = last_acc_q;
    underrun_d  = starve;

    // Drain first; a handshake in the same cycle refills the buffer.
    if (drain) begin
      shift_d    = buf_q;
      cur_last_d = buf_last_q;
      buf_full_d = 1'b0;
    end
    if (accept) begin
      buf_d      = tx_data;
      buf_last_d = tx_last;
      buf_full_d = 1'b1;
      last_acc_d = last_acc_q | tx_last;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d     = SYNC;
          bit_idx_d   = '0;
          ones_d      = '0;
          byte_done_d = 1'b0;
          cur_last_d  = 1'b0;
        end
      end
      SYNC, DATA: begin
        if (bit_end) begin
          ones_d = cur_bit ? ones_inc : 3'd0;
          if (stuff_needed) begin
            state_d     = STUFF;
            byte_done_d = last_bit;
            bit_idx_d   = bit_idx_q + 3'd1;
          end else if (last_bit) begin
            state_d   = drain ? DATA : EOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STUFF: begin
        // SYNC starts with seven zeros, so a stuff bit always resumes DATA.
        if (bit_end) begin
          ones_d      = '0;
          byte_done_d = 1'b0;
          if (byte_done_q) begin
            state_d   = drain ? DATA : EOP;
            bit_idx_d = '0;
          end else begin
            state_d = DATA;
          end
        end
      end
      EOP: begin
        if (bit_end) begin
          if (bit_idx_q == 3'(EOP_BITS - 1)) begin
            state_d   = EOP_J;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      EOP_J: begin
        if (bit_end) begin
          state_d    = IDLE;
          last_acc_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the holding byte and shift register are cleared on reset as well,
  // so no stale packet data can reach the line after an abort.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      ones_q      <= '0;
      byte_done_q <= 1'b0;
      shift_q     <= '0;
      cur_last_q  <= 1'b0;
      buf_q       <= '0;
      buf_last_q  <= 1'b0;
      buf_full_q  <= 1'b0;
      last_acc_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      ones_q      <= ones_d;
      byte_done_q <= byte_done_d;
      shift_q     <= shift_d;
      cur_last_q  <= cur_last_d;
      buf_q       <= buf_d;
      buf_last_q  <= buf_last_d;
      buf_full_q  <= buf_full_d;
      last_acc_q  <= last_acc_d;
      underrun_q  <= underrun_d;
    end
  end

`ifdef TX_BYTE_CNT_EN
  logic [6:0] byte_cnt_q, byte_cnt_d;

  // Counts completed payload bytes; a boundary leaving SYNC is not a byte.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if ((state_q == IDLE) && accept) begin
      byte_cnt_d = '0;
    end else if (at_boundary && (state_q != SYNC) && (byte_cnt_q != 7'd127)) begin
      byte_cnt_d = byte_cnt_q + 7'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      byte_cnt_q <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign byte_cnt = byte_cnt_q;
`endif

endmodule

// File: tb/tb_tx_bit_serializer.sv
// -----------------------------------------------------------------------------
// tb_tx_bit_serializer
// Self-checking bench for tx_bit_serializer. The expected line bit stream is
// computed from the protocol rules (SYNC 8'h80, bytes LSB first, a zero after
// every six consecutive ones) and compared with the bits seen on each
// shift_enable strobe; EOP/J length, underrun and handshake counts are
// checked against plain constants.
// -----------------------------------------------------------------------------
module tb_tx_bit_serializer;

  localparam int CLKS = 4;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       d_orig;
  logic       shift_enable;
  logic       eop;
  logic       busy;
  logic       underrun;

  tx_bit_serializer #(.CLKS_PER_BIT(CLKS)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .d_orig      (d_orig),
    .shift_enable(shift_enable),
    .eop         (eop),
    .busy        (busy),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] drv_bytes[$];
  bit         exp_bits[$];
  bit         got_bits[$];
  int eop_cycles, eop_d_bad, j_cycles, underrun_cnt, ready_cyc, gap_bad, se_after_eop;
  bit mon_timeout, feed_timeout;

  // Reference line stream: SYNC then payload, LSB first, zero after 6 ones.
  function automatic void build_expected();
    logic [7:0] seq[$];
    int ones;
    bit b;
    seq = drv_bytes;
    seq.push_front(8'h80);
    exp_bits.delete();
    ones = 0;
    foreach (seq[k]) begin
      for (int j = 0; j < 8; j++) begin
        b = bit'((seq[k] >> j) & 8'd1);
        exp_bits.push_back(b);
        ones = b ? ones + 1 : 0;
        if (ones == 6) begin
          exp_bits.push_back(1'b0);
          ones = 0;
        end
      end
    end
  endfunction

  function automatic int stream_diff();
    int n;
    n = (got_bits.size() < exp_bits.size()) ? got_bits.size() : exp_bits.size();
    for (int i = 0; i < n; i++) if (got_bits[i] != exp_bits[i]) return i;
    return (got_bits.size() == exp_bits.size()) ? -1 : n;
  endfunction

  function automatic logic [15:0] pack16();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 16 && i < got_bits.size(); i++) v[15-i] = got_bits[i];
    return v;
  endfunction

  task automatic feed(input bit with_last);
    int w;
    for (int i = 0; i < drv_bytes.size(); i++) begin
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = drv_bytes[i];
      tx_last  = with_last && (i == drv_bytes.size() - 1);
      w = 0;
      while (!tx_ready && w < 1000) begin
        @(negedge clk);
        w++;
      end
      if (!tx_ready) begin
        feed_timeout = 1'b1;
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  task automatic monitor();
    int cyc, last_se;
    bit eop_seen;
    cyc = 0;
    last_se = -1;
    eop_seen = 1'b0;
    for (int c = 0; c < 50 && !busy; c++) @(negedge clk);
    if (!busy) mon_timeout = 1'b1;
    while (busy && cyc < 3000) begin
      if (shift_enable) begin
        got_bits.push_back(d_orig);
        if (last_se >= 0 && cyc - last_se != CLKS) gap_bad++;
        if (eop_seen) se_after_eop++;
        last_se = cyc;
      end
      if (eop) begin
        eop_seen = 1'b1;
        eop_cycles++;
        if (d_orig !== 1'b1) eop_d_bad++;
      end else if (eop_seen) begin
        j_cycles++;
      end
      if (underrun) underrun_cnt++;
      if (tx_ready) ready_cyc++;
      cyc++;
      @(negedge clk);
    end
    if (busy) mon_timeout = 1'b1;
  endtask

  task automatic run_packet(input bit with_last);
    got_bits.delete();
    eop_cycles = 0; eop_d_bad = 0; j_cycles = 0; underrun_cnt = 0;
    ready_cyc = 0; gap_bad = 0; se_after_eop = 0;
    mon_timeout = 1'b0; feed_timeout = 1'b0;
    build_expected();
    fork
      feed(with_last);
      monitor();
    join
  endtask

  task automatic test_reset();
    n_rst = 1'b0; tx_valid = 1'b0; tx_last = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({d_orig, shift_enable, eop, busy, underrun} !== 5'b10000) begin
      bad++; $display("FAIL reset_outputs: got %b required 10000", {d_orig, shift_enable, eop, busy, underrun});
    end
    n_rst = 1'b1;
    @(negedge clk);
    total++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_ready: got ready=%b busy=%b required ready=1 busy=0", tx_ready, busy);
    end
  endtask

  task automatic test_single_a5();
    drv_bytes = {8'hA5};
    run_packet(1'b1);
    total++; if (mon_timeout || feed_timeout) begin bad++; $display("FAIL a5_timeout: got timeout required completion"); end
    total++; if (got_bits.size() !== 16) begin bad++; $display("FAIL a5_pulses: got %0d required 16", got_bits.size()); end
    total++; if (pack16() !== 16'b0000_0001_1010_0101) begin bad++; $display("FAIL a5_bits: got %b required 0000000110100101", pack16()); end
    total++; if (eop_cycles !== 2 * CLKS) begin bad++; $display("FAIL a5_eop_len: got %0d required %0d", eop_cycles, 2 * CLKS); end
    total++; if (j_cycles !== CLKS) begin bad++; $display("FAIL a5_j_len: got %0d required %0d", j_cycles, CLKS); end
    total++; if (eop_d_bad !== 0) begin bad++; $display("FAIL a5_eop_dorig: got %0d low cycles required 0", eop_d_bad); end
    total++; if (underrun_cnt !== 0) begin bad++; $display("FAIL a5_underrun: got %0d required 0", underrun_cnt); end
    total++; if (gap_bad !== 0) begin bad++; $display("FAIL a5_spacing: got %0d bad gaps required 0", gap_bad); end
  endtask

  task automatic test_stuff_ff00();
    drv_bytes = {8'hFF, 8'h00};
    run_packet(1'b1);
    total++; if (got_bits.size() !== 25) begin bad++; $display("FAIL ff00_pulses: got %0d required 25", got_bits.size()); end
    total++; if (stream_diff() !== -1) begin bad++; $display("FAIL ff00_stream: got first diff at %0d required none", stream_diff()); end
    total++; if (got_bits.size() < 15 || got_bits[13] !== 1'b0 || got_bits[14] !== 1'b1) begin
      bad++; $display("FAIL ff00_stuff_pos: got size=%0d required bit13=0 bit14=1", got_bits.size());
    end
    total++; if (eop_cycles !== 2 * CLKS || underrun_cnt !== 0) begin
      bad++; $display("FAIL ff00_eop: got eop=%0d underrun=%0d required %0d/0", eop_cycles, underrun_cnt, 2 * CLKS);
    end
  endtask

  task automatic test_stuff_7e();
    drv_bytes = {8'h7E};
    run_packet(1'b1);
    total++; if (got_bits.size() !== 17) begin bad++; $display("FAIL 7e_pulses: got %0d required 17", got_bits.size()); end
    total++; if (stream_diff() !== -1) begin bad++; $display("FAIL 7e_stream: got first diff at %0d required none", stream_diff()); end
    total++; if (got_bits.size() < 17 || got_bits[15] !== 1'b0 || got_bits[16] !== 1'b0) begin
      bad++; $display("FAIL 7e_tail: got size=%0d required stuff 0 then data 0", got_bits.size());
    end
    total++; if (se_after_eop !== 0 || eop_cycles !== 2 * CLKS) begin
      bad++; $display("FAIL 7e_eop_order: got late strobes=%0d eop=%0d required 0/%0d", se_after_eop, eop_cycles, 2 * CLKS);
    end
  endtask

  task automatic test_stuff_before_eop();
    drv_bytes = {8'hFC};
    run_packet(1'b1);
    total++; if (got_bits.size() !== 17 || stream_diff() !== -1) begin
      bad++; $display("FAIL owed_stuff_stream: got size=%0d diff=%0d required 17/none", got_bits.size(), stream_diff());
    end
    total++; if (se_after_eop !== 0 || eop_cycles !== 2 * CLKS || j_cycles !== CLKS) begin
      bad++; $display("FAIL owed_stuff_eop: got late=%0d eop=%0d j=%0d required 0/%0d/%0d", se_after_eop, eop_cycles, j_cycles, 2 * CLKS, CLKS);
    end
  endtask

  task automatic test_underrun();
    drv_bytes = {8'h3C, 8'hC3};
    run_packet(1'b0);
    total++; if (mon_timeout || feed_timeout) begin bad++; $display("FAIL underrun_timeout: got timeout required completion"); end
    total++; if (underrun_cnt !== 1) begin bad++; $display("FAIL underrun_pulse: got %0d required 1", underrun_cnt); end
    total++; if (stream_diff() !== -1) begin bad++; $display("FAIL underrun_stream: got first diff at %0d required none", stream_diff()); end
    total++; if (eop_cycles !== 2 * CLKS || j_cycles !== CLKS) begin
      bad++; $display("FAIL underrun_eop: got eop=%0d j=%0d required %0d/%0d", eop_cycles, j_cycles, 2 * CLKS, CLKS);
    end
  endtask

  task automatic test_reset_mid();
    int  se_seen, c;
    logic busy_before;
    se_seen = 0;
    c = 0;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h5A; tx_last = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0; tx_last = 1'b0;
    while (se_seen < 10 && c < 500) begin
      if (shift_enable) se_seen++;
      c++;
      @(negedge clk);
    end
    total++; if (se_seen !== 10) begin bad++; $display("FAIL midreset_reach: got %0d strobes required 10", se_seen); end
    busy_before = busy;
    n_rst = 1'b0;
    @(negedge clk);
    total++; if (busy_before !== 1'b1) begin bad++; $display("FAIL midreset_busy_before: got %b required 1", busy_before); end
    total++;
    if ({d_orig, shift_enable, eop, busy, underrun} !== 5'b10000) begin
      bad++; $display("FAIL midreset_outputs: got %b required 10000", {d_orig, shift_enable, eop, busy, underrun});
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready: got %b required 1", tx_ready); end
    drv_bytes = {8'hA5};
    run_packet(1'b1);
    total++; if (got_bits.size() !== 16 || pack16() !== 16'b0000_0001_1010_0101) begin
      bad++; $display("FAIL midreset_restart: got %0d bits %b required 16 bits 0000000110100101", got_bits.size(), pack16());
    end
  endtask

  task automatic test_back_to_back();
    drv_bytes.delete();
    for (int i = 0; i < 4; i++) drv_bytes.push_back(8'($urandom_range(0, 255)));
    run_packet(1'b1);
    total++; if (stream_diff() !== -1) begin bad++; $display("FAIL b2b_stream: got first diff at %0d required none", stream_diff()); end
    total++; if (gap_bad !== 0) begin bad++; $display("FAIL b2b_gaps: got %0d bad gaps required 0", gap_bad); end
    total++; if (ready_cyc !== 3) begin bad++; $display("FAIL b2b_ready: got %0d busy ready cycles required 3", ready_cyc); end
  endtask

  task automatic test_random();
    int n;
    logic [7:0] b;
    for (int p = 0; p < 20; p++) begin
      n = $urandom_range(1, 5);
      drv_bytes.delete();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) b = b | 8'hE7;
        drv_bytes.push_back(b);
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_packet(1'b1);
      total++; if (mon_timeout || feed_timeout || stream_diff() !== -1) begin
        bad++; $display("FAIL rnd_stream p%0d: got diff=%0d timeout=%b required none", p, stream_diff(), mon_timeout | feed_timeout);
      end
      total++; if (eop_cycles !== 2 * CLKS || j_cycles !== CLKS || underrun_cnt !== 0) begin
        bad++; $display("FAIL rnd_eop p%0d: got eop=%0d j=%0d ur=%0d required %0d/%0d/0", p, eop_cycles, j_cycles, underrun_cnt, 2 * CLKS, CLKS);
      end
      total++; if (ready_cyc !== n - 1 || gap_bad !== 0) begin
        bad++; $display("FAIL rnd_flow p%0d: got ready=%0d gaps=%0d required %0d/0", p, ready_cyc, gap_bad, n - 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_stuff_ff00();
    test_stuff_7e();
    test_stuff_before_eop();
    test_underrun();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
